// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Produces the stage enable, bubble and flush controls for a
//            5-stage pipeline. It covers load-use hazards, ID-stage branch
//            operand hazards, redirects and multi-cycle data-memory waits.
//            It also keeps stall and bubble performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_id_is_branch,
    input  logic             i_id_redirect,
    input  logic             i_id_ex_valid,
    input  logic [4:0]       i_id_ex_rd,
    input  logic             i_id_ex_reg_write,
    input  logic             i_id_ex_mem_read,
    input  logic             i_ex_mem_valid,
    input  logic [4:0]       i_ex_mem_rd,
    input  logic             i_ex_mem_mem_read,
    input  logic             i_ex_mem_mem_access,
    input  logic             i_lsu_ready,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_bubble,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_bubble,
    output logic             o_state,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_bubble_count
);

    localparam int                  c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [c_WAIT_W-1:0] r_wait_q;
    logic [c_WAIT_W-1:0] w_wait_d;
    logic                r_timeout_q;
    logic                w_timeout_d;
    logic [CNT_W-1:0]    r_stall_cnt_q;
    logic [CNT_W-1:0]    w_stall_cnt_d;
    logic [CNT_W-1:0]    r_bubble_cnt_q;
    logic [CNT_W-1:0]    w_bubble_cnt_d;

    // Register x0 is never a real producer, so rd = 0 cannot create a hazard.
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_match_ex;
    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_id_stall;
    logic w_mem_busy;
    logic w_redirect;

    assign w_ex_hit   = (i_id_ex_rd != 5'd0) &&
                        ((i_id_use_rs1 && (i_id_rs1 == i_id_ex_rd)) ||
                         (i_id_use_rs2 && (i_id_rs2 == i_id_ex_rd)));
    assign w_mem_hit  = (i_ex_mem_rd != 5'd0) &&
                        ((i_id_use_rs1 && (i_id_rs1 == i_ex_mem_rd)) ||
                         (i_id_use_rs2 && (i_id_rs2 == i_ex_mem_rd)));
    assign w_match_ex = i_id_valid && i_id_ex_valid && i_id_ex_reg_write && w_ex_hit;
    assign w_load_use = w_match_ex && i_id_ex_mem_read;
    // A branch compares in ID, so even an ALU result in EX is too late for it.
    assign w_br_ex    = i_id_is_branch && w_match_ex;
    assign w_br_mem   = i_id_valid && i_id_is_branch && i_ex_mem_valid &&
                        i_ex_mem_mem_read && w_mem_hit;
    assign w_id_stall = w_load_use || w_br_ex || w_br_mem;
    assign w_mem_busy = i_ex_mem_valid && i_ex_mem_mem_access && !i_lsu_ready;
    assign w_redirect = i_id_valid && i_id_redirect;

    // Stage controls: reset, then memory freeze, then ID stall, then redirect.
    always_comb begin
        o_pc_en         = 1'b1;
        o_if_id_en      = 1'b1;
        o_if_id_flush   = 1'b0;
        o_id_ex_en      = 1'b1;
        o_id_ex_bubble  = 1'b0;
        o_ex_mem_en     = 1'b1;
        o_mem_wb_bubble = 1'b0;
        if (i_reset) begin
            o_pc_en         = 1'b0;
            o_if_id_en      = 1'b0;
            o_if_id_flush   = 1'b1;
            o_id_ex_en      = 1'b0;
            o_id_ex_bubble  = 1'b1;
            o_ex_mem_en     = 1'b0;
            o_mem_wb_bubble = 1'b1;
        end else if (w_mem_busy) begin
            // Whole front of the pipe holds; only MEM/WB drains a bubble.
            o_pc_en         = 1'b0;
            o_if_id_en      = 1'b0;
            o_id_ex_en      = 1'b0;
            o_ex_mem_en     = 1'b0;
            o_mem_wb_bubble = 1'b1;
        end else if (w_id_stall) begin
            // Redirect is ignored here: the branch operands are stale.
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_bubble = 1'b1;
        end else if (w_redirect) begin
            o_if_id_flush = 1'b1;
        end
    end

    // Next-state for FSM, wait counter, sticky timeout and perf counters.
    always_comb begin
        w_state_d      = w_mem_busy ? ST_MEM_WAIT : ST_RUN;
        w_wait_d       = '0;
        w_timeout_d    = r_timeout_q;
        w_stall_cnt_d  = r_stall_cnt_q + (o_pc_en ? '0 : CNT_W'(1));
        w_bubble_cnt_d = r_bubble_cnt_q + (o_id_ex_bubble ? CNT_W'(1) : '0);
        if (r_state_q == ST_MEM_WAIT) begin
            w_wait_d = (r_wait_q == c_WAIT_MAX) ? r_wait_q : r_wait_q + c_WAIT_W'(1);
            if (w_wait_d == c_WAIT_MAX) begin
                w_timeout_d = 1'b1;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state_q      <= ST_RUN;
            r_wait_q       <= '0;
            r_timeout_q    <= 1'b0;
            r_stall_cnt_q  <= '0;
            r_bubble_cnt_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_wait_q       <= w_wait_d;
            r_timeout_q    <= w_timeout_d;
            r_stall_cnt_q  <= w_stall_cnt_d;
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    assign o_state        = r_state_q;
    assign o_mem_timeout  = r_timeout_q;
    assign o_stall_count  = r_stall_cnt_q;
    assign o_bubble_count = r_bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Scoreboard bench for hazard_stall_ctrl: directed scenarios plus
//            random pipeline states, checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int c_TIMEOUT = 4;
    localparam int c_CNT_W   = 32;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic       is_br;
        logic       redir;
        logic       idex_valid;
        logic [4:0] idex_rd;
        logic       idex_rw;
        logic       idex_mr;
        logic       exm_valid;
        logic [4:0] exm_rd;
        logic       exm_mr;
        logic       exm_ma;
        logic       lsu_ready;
    } stim_t;

    typedef struct packed {
        logic        pc_en;
        logic        if_id_en;
        logic        if_id_flush;
        logic        id_ex_en;
        logic        id_ex_bubble;
        logic        ex_mem_en;
        logic        mem_wb_bubble;
        logic        state;
        logic        timeout;
        logic [31:0] stall;
        logic [31:0] bub;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 0, use1 = 0, use2 = 0, is_br = 0, redir = 0;
    logic [4:0] rs1 = 0, rs2 = 0, idex_rd = 0, exm_rd = 0;
    logic idex_valid = 0, idex_rw = 0, idex_mr = 0;
    logic exm_valid = 0, exm_mr = 0, exm_ma = 0, lsu_ready = 1;

    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble;
    logic state, timeout;
    logic [c_CNT_W-1:0] stall_cnt, bub_cnt;

    hazard_stall_ctrl #(.MEM_TIMEOUT(c_TIMEOUT), .CNT_W(c_CNT_W)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_id_valid         (id_valid),
        .i_id_rs1           (rs1),
        .i_id_rs2           (rs2),
        .i_id_use_rs1       (use1),
        .i_id_use_rs2       (use2),
        .i_id_is_branch     (is_br),
        .i_id_redirect      (redir),
        .i_id_ex_valid      (idex_valid),
        .i_id_ex_rd         (idex_rd),
        .i_id_ex_reg_write  (idex_rw),
        .i_id_ex_mem_read   (idex_mr),
        .i_ex_mem_valid     (exm_valid),
        .i_ex_mem_rd        (exm_rd),
        .i_ex_mem_mem_read  (exm_mr),
        .i_ex_mem_mem_access(exm_ma),
        .i_lsu_ready        (lsu_ready),
        .o_pc_en            (pc_en),
        .o_if_id_en         (if_id_en),
        .o_if_id_flush      (if_id_flush),
        .o_id_ex_en         (id_ex_en),
        .o_id_ex_bubble     (id_ex_bubble),
        .o_ex_mem_en        (ex_mem_en),
        .o_mem_wb_bubble    (mem_wb_bubble),
        .o_state            (state),
        .o_mem_timeout      (timeout),
        .o_stall_count      (stall_cnt),
        .o_bubble_count     (bub_cnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model state: what the controller should remember.
    bit          m_waiting = 0;
    int          m_wait    = 0;
    bit          m_to      = 0;
    logic [31:0] m_stall   = 0;
    logic [31:0] m_bub     = 0;

    function automatic bit reads(input logic [4:0] rd, input stim_t s);
        return (rd != 0) && ((s.use1 && s.rs1 == rd) || (s.use2 && s.rs2 == rd));
    endfunction

    // Decide which single pipeline action the rules call for this cycle.
    // 0 reset, 1 memory freeze, 2 ID stall, 3 redirect, 4 free flow.
    function automatic int action(input stim_t s);
        bit producer_in_ex, hazard;
        if (s.rst) return 0;
        if (s.exm_valid && s.exm_ma && !s.lsu_ready) return 1;
        producer_in_ex = s.id_valid && s.idex_valid && s.idex_rw && reads(s.idex_rd, s);
        hazard = (producer_in_ex && (s.idex_mr || s.is_br)) ||
                 (s.id_valid && s.is_br && s.exm_valid && s.exm_mr && reads(s.exm_rd, s));
        if (hazard) return 2;
        if (s.id_valid && s.redir) return 3;
        return 4;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        int   a;
        @(posedge clk);
        #1;
        rst = s.rst; id_valid = s.id_valid; rs1 = s.rs1; rs2 = s.rs2;
        use1 = s.use1; use2 = s.use2; is_br = s.is_br; redir = s.redir;
        idex_valid = s.idex_valid; idex_rd = s.idex_rd; idex_rw = s.idex_rw;
        idex_mr = s.idex_mr; exm_valid = s.exm_valid; exm_rd = s.exm_rd;
        exm_mr = s.exm_mr; exm_ma = s.exm_ma; lsu_ready = s.lsu_ready;
        a = action(s);
        // {pc, if_id_en, flush, id_ex_en, bubble, ex_mem_en, wb_bubble}
        case (a)
            0:       {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_bubble, e.ex_mem_en, e.mem_wb_bubble} = 7'b0010101;
            1:       {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_bubble, e.ex_mem_en, e.mem_wb_bubble} = 7'b0000001;
            2:       {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_bubble, e.ex_mem_en, e.mem_wb_bubble} = 7'b0001110;
            3:       {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_bubble, e.ex_mem_en, e.mem_wb_bubble} = 7'b1111010;
            default: {e.pc_en, e.if_id_en, e.if_id_flush, e.id_ex_en, e.id_ex_bubble, e.ex_mem_en, e.mem_wb_bubble} = 7'b1101010;
        endcase
        e.state   = m_waiting;
        e.timeout = m_to;
        e.stall   = m_stall;
        e.bub     = m_bub;
        q.push_back(e);
        if (s.rst) begin
            m_waiting = 0; m_wait = 0; m_to = 0; m_stall = 0; m_bub = 0;
        end else begin
            if (!e.pc_en) m_stall = m_stall + 1;
            if (e.id_ex_bubble) m_bub = m_bub + 1;
            if (m_waiting) begin
                if (m_wait < c_TIMEOUT) m_wait = m_wait + 1;
                if (m_wait == c_TIMEOUT) m_to = 1;
            end else begin
                m_wait = 0;
            end
            m_waiting = (a == 1);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a full control word; compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pc_en",         32'(pc_en),         32'(e.pc_en));
                check("if_id_en",      32'(if_id_en),      32'(e.if_id_en));
                check("if_id_flush",   32'(if_id_flush),   32'(e.if_id_flush));
                check("id_ex_en",      32'(id_ex_en),      32'(e.id_ex_en));
                check("id_ex_bubble",  32'(id_ex_bubble),  32'(e.id_ex_bubble));
                check("ex_mem_en",     32'(ex_mem_en),     32'(e.ex_mem_en));
                check("mem_wb_bubble", 32'(mem_wb_bubble), 32'(e.mem_wb_bubble));
                check("state",         32'(state),         32'(e.state));
                check("mem_timeout",   32'(timeout),       32'(e.timeout));
                check("stall_count",   stall_cnt,          e.stall);
                check("bubble_count",  bub_cnt,            e.bub);
            end
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        s.lsu_ready = 1'b1;
        return s;
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd7;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        stim_t s;
        // Reset
        s = nop(); s.rst = 1;
        repeat (3) apply(s);

        // Load-use: lw x5 in ID/EX, add reading x5 in ID
        s = nop(); s.id_valid = 1; s.rs1 = 5; s.use1 = 1;
        s.idex_valid = 1; s.idex_rd = 5; s.idex_rw = 1; s.idex_mr = 1;
        apply(s);
        s.idex_valid = 0;
        apply(s);
        apply(nop());

        // Branch after ALU write of x7: one stall
        s = nop(); s.id_valid = 1; s.rs2 = 7; s.use2 = 1; s.is_br = 1;
        s.idex_valid = 1; s.idex_rd = 7; s.idex_rw = 1;
        apply(s);
        s.idex_valid = 0; s.exm_valid = 1; s.exm_rd = 7;
        apply(s);
        apply(nop());

        // Branch after lw x7: two stalls
        s = nop(); s.id_valid = 1; s.rs2 = 7; s.use2 = 1; s.is_br = 1;
        s.idex_valid = 1; s.idex_rd = 7; s.idex_rw = 1; s.idex_mr = 1;
        apply(s);
        s.idex_valid = 0; s.exm_valid = 1; s.exm_rd = 7; s.exm_mr = 1; s.exm_ma = 1;
        apply(s);
        s.exm_valid = 0;
        apply(s);

        // Branch against rd = 0: no stall
        s = nop(); s.id_valid = 1; s.rs2 = 0; s.use2 = 1; s.is_br = 1;
        s.idex_valid = 1; s.idex_rd = 0; s.idex_rw = 1; s.idex_mr = 1;
        apply(s);

        // Store waiting three cycles, ready on the fourth
        s = nop(); s.exm_valid = 1; s.exm_ma = 1; s.lsu_ready = 0;
        repeat (3) apply(s);
        s.lsu_ready = 1;
        apply(s);
        apply(nop());

        // Memory busy together with load-use and redirect
        s = nop(); s.id_valid = 1; s.rs1 = 5; s.use1 = 1; s.redir = 1; s.is_br = 1;
        s.idex_valid = 1; s.idex_rd = 5; s.idex_rw = 1; s.idex_mr = 1;
        s.exm_valid = 1; s.exm_ma = 1; s.lsu_ready = 0;
        repeat (2) apply(s);
        s.lsu_ready = 1;
        apply(s);
        s.idex_valid = 0; s.exm_valid = 0;
        apply(s);
        apply(nop());

        // Plain redirect
        s = nop(); s.id_valid = 1; s.redir = 1; s.is_br = 1;
        apply(s);
        apply(nop());

        // Timeout: held-off memory, then reset clears everything
        s = nop(); s.exm_valid = 1; s.exm_mr = 1; s.exm_ma = 1; s.lsu_ready = 0;
        repeat (6) apply(s);
        s.lsu_ready = 1;
        apply(s);
        repeat (2) apply(nop());
        s = nop(); s.rst = 1;
        apply(s);
        apply(nop());

        // Random pipeline states
        for (int i = 0; i < 500; i++) begin
            s.rst        = ($urandom_range(0, 59) == 0);
            s.id_valid   = ($urandom_range(0, 3) != 0);
            s.rs1        = rreg();
            s.rs2        = rreg();
            s.use1       = 1'($urandom);
            s.use2       = 1'($urandom);
            s.is_br      = 1'($urandom);
            s.redir      = 1'($urandom);
            s.idex_valid = 1'($urandom);
            s.idex_rd    = rreg();
            s.idex_rw    = ($urandom_range(0, 3) != 0);
            s.idex_mr    = 1'($urandom);
            s.exm_valid  = 1'($urandom);
            s.exm_rd     = rreg();
            s.exm_mr     = 1'($urandom);
            s.exm_ma     = s.exm_mr | ($urandom_range(0, 2) == 0);
            s.lsu_ready  = ($urandom_range(0, 2) != 0);
            apply(s);
        end

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
